// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank: CTRL, STATUS, IRQ_STATUS/IRQ_MASK and CFG0..CFG3 for the Ethernet MAC.
// Latency: B response one cycle after the AW/W pair completes; R response the cycle after the AR handshake.
// Backpressure: one outstanding write and one outstanding read; no new request is accepted until B/R has handshaked.
// Build option: define AXIL_SLAVE_IRQ_EN to implement IRQ_STATUS/IRQ_MASK and the irq output.
module axi4_lite_slave_regs #(
  parameter int          data_width = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      AWvalid,
  output logic                      AWready,
  input  logic [31:0]               AWaddr,
  input  logic                      Wvalid,
  output logic                      Wready,
  input  logic [data_width-1:0]     Wdata,
  input  logic [data_width/8-1:0]   Wstrb,
  output logic                      Bvalid,
  input  logic                      Bready,
  output logic [1:0]                Bresp,
  input  logic                      ARvalid,
  output logic                      ARready,
  input  logic [31:0]               ARaddr,
  output logic                      Rvalid,
  input  logic                      Rready,
  output logic [data_width-1:0]     Rdata,
  output logic [1:0]                Rresp,
  output logic [data_width-1:0]     ctrl_out,
  output logic [4*data_width-1:0]   cfg_out,
  input  logic [data_width-1:0]     status_in,
  input  logic [data_width-1:0]     irq_event,
  output logic                      irq
);

  localparam int DW = data_width;
  localparam int SW = data_width / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Expand byte strobes into a bit mask.
  function automatic logic [DW-1:0] lane_mask(input logic [SW-1:0] strb);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < SW; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

  // Register storage
  logic [DW-1:0] ctrl_q;
  logic [DW-1:0] cfg_q [4];

  // Write channel state
  wstate_t       w_state, w_next;
  logic          w_commit_q, w_commit_d;  // both halves captured; register update on next edge
  logic [31:2]   waddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          aw_hs, w_hs;
  logic          w_hit, w_do;
  logic [2:0]    w_idx;
  logic [1:0]    w_resp;
  logic [DW-1:0] w_mask;

  // Read channel state
  rstate_t       r_state, r_next;
  logic          ar_hs, r_hit;
  logic [2:0]    r_idx;
  logic [DW-1:0] rd_word;

  // Address bits [1:0] carry no information for word-aligned registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWaddr[1:0], ARaddr[1:0]};

  assign w_hit  = (waddr_q[31:5] == BASE_ADDR[31:5]);
  assign w_idx  = waddr_q[4:2];
  assign w_do   = w_commit_q && w_hit;
  assign w_mask = lane_mask(wstrb_q);
  assign w_resp = !w_hit ? 2'b11 : (w_idx == 3'd1) ? 2'b10 : 2'b00;

  // Write handshakes; readies stay low during reset and while an update is pending.
  always_comb begin
    AWready = !reset && !w_commit_q && (w_state == W_IDLE || w_state == W_HAVE_D);
    Wready  = !reset && !w_commit_q && (w_state == W_IDLE || w_state == W_HAVE_A);
    Bvalid  = (w_state == W_RESP);
    aw_hs   = AWvalid && AWready;
    w_hs    = Wvalid && Wready;
  end

  // Write FSM next state: pair completion schedules the update, which then moves to W_RESP.
  always_comb begin
    w_next     = w_state;
    w_commit_d = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_commit_d = 1'b1;
        else if (aw_hs)    w_next = W_HAVE_A;
        else if (w_hs)     w_next = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  w_commit_d = 1'b1;
      W_HAVE_D: if (aw_hs) w_commit_d = 1'b1;
      W_RESP:   if (Bready) w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
    if (w_commit_q) w_next = W_RESP;
  end

  // Write FSM state register and response code.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state    <= W_IDLE;
      w_commit_q <= 1'b0;
      Bresp      <= 2'b00;
    end else begin
      w_state    <= w_next;
      w_commit_q <= w_commit_d;
      if (w_commit_q) Bresp <= w_resp;
    end
  end

  // Capture address and data halves as they are accepted.
  always_ff @(posedge clk) begin
    if (aw_hs) waddr_q <= AWaddr[31:2];
    if (w_hs) begin
      wdata_q <= Wdata;
      wstrb_q <= Wstrb;
    end
  end

  // CTRL and CFG updates with byte-lane merge; decode misses and STATUS writes change nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= CTRL_RESET[DW-1:0];
      for (int i = 0; i < 4; i++) cfg_q[i] <= '0;
    end else if (w_do) begin
      if (w_idx == 3'd0) ctrl_q <= (ctrl_q & ~w_mask) | (wdata_q & w_mask);
      if (w_idx[2])      cfg_q[w_idx[1:0]] <= (cfg_q[w_idx[1:0]] & ~w_mask) | (wdata_q & w_mask);
    end
  end

`ifdef AXIL_SLAVE_IRQ_EN
  logic [DW-1:0] irq_status_q, irq_mask_q, irq_clr;
  assign irq_clr = (w_do && w_idx == 3'd2) ? (wdata_q & w_mask) : '0;

  // Interrupt status (set beats a same-cycle clear) and mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_status_q <= '0;
      irq_mask_q   <= '0;
    end else begin
      irq_status_q <= (irq_status_q & ~irq_clr) | irq_event;
      if (w_do && w_idx == 3'd3) irq_mask_q <= (irq_mask_q & ~w_mask) | (wdata_q & w_mask);
    end
  end

  assign irq = |(irq_status_q & irq_mask_q);
`else
  logic unused_irq_event;
  assign unused_irq_event = ^irq_event;
  assign irq = 1'b0;
`endif

  assign ctrl_out = ctrl_q;
  assign cfg_out  = {cfg_q[3], cfg_q[2], cfg_q[1], cfg_q[0]};

  assign r_hit = (ARaddr[31:5] == BASE_ADDR[31:5]);
  assign r_idx = ARaddr[4:2];

  // Read data select from the current (pre-update) register contents.
  always_comb begin
    rd_word = '0;
    case (r_idx)
      3'd0: rd_word = ctrl_q;
      3'd1: rd_word = status_in;
`ifdef AXIL_SLAVE_IRQ_EN
      3'd2: rd_word = irq_status_q;
      3'd3: rd_word = irq_mask_q;
`endif
      3'd4: rd_word = cfg_q[0];
      3'd5: rd_word = cfg_q[1];
      3'd6: rd_word = cfg_q[2];
      3'd7: rd_word = cfg_q[3];
      default: rd_word = '0;
    endcase
  end

  // Read handshakes and FSM next state.
  always_comb begin
    ARready = !reset && (r_state == R_IDLE);
    Rvalid  = (r_state == R_DATA);
    ar_hs   = ARvalid && ARready;
    r_next  = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)  r_next = R_DATA;
      R_DATA:  if (Rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM state and response registers; data is held stable while Rvalid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      Rdata   <= '0;
      Rresp   <= 2'b00;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        Rdata <= r_hit ? rd_word : '0;
        Rresp <= r_hit ? 2'b00 : 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs with response scoreboards.
// Expected B/R responses are queued when a request is driven and popped when the DUT answers.
// Interrupt expectations follow AXIL_SLAVE_IRQ_EN as seen by this compilation.
module tb_axi4_lite_slave_regs;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] CR   = 32'h0000_0C0D;
`ifdef AXIL_SLAVE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
  logic          ARvalid, ARready, Rvalid, Rready, irq;
  logic [31:0]   AWaddr, Wdata, ARaddr, Rdata, ctrl_out, status_in, irq_event;
  logic [3:0]    Wstrb;
  logic [1:0]    Bresp, Rresp;
  logic [127:0]  cfg_out;

  int checks   = 0;
  int failures = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  axi4_lite_slave_regs #(.data_width(32), .BASE_ADDR(BASE), .CTRL_RESET(CR)) dut (
    .clk(clk), .reset(reset),
    .AWvalid(AWvalid), .AWready(AWready), .AWaddr(AWaddr),
    .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
    .ARvalid(ARvalid), .ARready(ARready), .ARaddr(ARaddr),
    .Rvalid(Rvalid), .Rready(Rready), .Rdata(Rdata), .Rresp(Rresp),
    .ctrl_out(ctrl_out), .cfg_out(cfg_out), .status_in(status_in),
    .irq_event(irq_event), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One write; W is driven first, AW w_lead cycles later. irq_pulse lands on the update edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input int w_lead,
                           input logic [31:0] irq_pulse, input bit hold_b);
    bit aw_done = 0;
    bit w_done  = 0;
    int c = 0;
    int lat = 0;
    logic [1:0] e;
    bq.push_back(exp_resp);
    AWaddr = addr; Wdata = data; Wstrb = strb;
    Wvalid = 1'b1;
    AWvalid = (w_lead == 0);
    while (!(aw_done && w_done) && c < 40) begin
      bit awh, wh;
      awh = AWvalid && AWready;
      wh  = Wvalid && Wready;
      @(posedge clk); #1; c++;
      if (awh) begin aw_done = 1; AWvalid = 1'b0; end
      if (wh)  begin w_done = 1;  Wvalid = 1'b0;  end
      if (w_done && !aw_done) check("wready_low_waiting_aw", 32'(Wready), 0);
      if (!aw_done && c >= w_lead) AWvalid = 1'b1;
    end
    check("aw_w_handshake", 32'(aw_done && w_done), 1);
    irq_event = irq_pulse;
    while (!Bvalid && lat < 20) begin
      @(posedge clk); #1; lat++;
      irq_event = '0;
    end
    irq_event = '0;
    check("b_latency", 32'(lat), 1);
    e = bq.pop_front();
    check("bresp", 32'(Bresp), 32'(e));
    if (!hold_b) begin
      Bready = 1'b1;
      @(posedge clk); #1;
      Bready = 1'b0;
      check("bvalid_drop", 32'(Bvalid), 0);
    end
  endtask

  // One read; Rready is held low for 'hold' cycles while Rvalid is up.
  task automatic axi_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data, input int hold);
    bit done = 0;
    int c = 0;
    logic [33:0] e;
    rq.push_back({exp_resp, exp_data});
    ARaddr = addr; ARvalid = 1'b1;
    while (!done && c < 40) begin
      bit h;
      h = ARvalid && ARready;
      @(posedge clk); #1; c++;
      if (h) begin done = 1; ARvalid = 1'b0; end
    end
    check("ar_handshake", 32'(done), 1);
    check("rvalid_latency", 32'(Rvalid), 1);
    e = rq.pop_front();
    check("rresp", 32'(Rresp), 32'(e[33:32]));
    check("rdata", Rdata, e[31:0]);
    for (int i = 0; i < hold; i++) begin
      status_in = ~status_in;
      @(posedge clk); #1;
      check("rvalid_hold", 32'(Rvalid), 1);
      check("rdata_hold", Rdata, e[31:0]);
      check("arready_blocked", 32'(ARready), 0);
    end
    Rready = 1'b1;
    @(posedge clk); #1;
    Rready = 1'b0;
    check("rvalid_drop", 32'(Rvalid), 0);
  endtask

  initial begin
    reset = 1'b1;
    AWvalid = 0; Wvalid = 0; Bready = 0; ARvalid = 0; Rready = 0;
    AWaddr = '0; Wdata = '0; Wstrb = '0; ARaddr = '0;
    status_in = '0; irq_event = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_awready", 32'(AWready), 0);
    check("rst_wready", 32'(Wready), 0);
    check("rst_arready", 32'(ARready), 0);
    check("rst_bvalid", 32'(Bvalid), 0);
    check("rst_rvalid", 32'(Rvalid), 0);
    check("rst_bresp", 32'(Bresp), 0);
    check("rst_rresp", 32'(Rresp), 0);
    check("rst_rdata", Rdata, 0);
    check("rst_ctrl", ctrl_out, CR);
    check("rst_cfg0", cfg_out[31:0], 0);
    check("rst_irq", 32'(irq), 0);
    reset = 1'b0;
    #1;
    check("post_rst_awready", 32'(AWready), 1);
    check("post_rst_wready", 32'(Wready), 1);
    check("post_rst_arready", 32'(ARready), 1);

    // AW and W together to CTRL
    axi_write(BASE + 32'h00, 32'hA5A5_1234, 4'hF, 2'b00, 0, '0, 0);
    check("ctrl_full_write", ctrl_out, 32'hA5A5_1234);

    // W leads AW by three cycles, partial strobes to CFG0
    axi_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0101, 2'b00, 3, '0, 0);
    check("cfg0_strobe", cfg_out[31:0], 32'h00FF_00FF);
    axi_read(BASE + 32'h10, 2'b00, 32'h00FF_00FF, 0);

    // Low byte of CTRL only, with ignored address LSBs
    axi_write(BASE + 32'h03, 32'h0000_00EE, 4'b0001, 2'b00, 0, '0, 0);
    check("ctrl_byte0", ctrl_out, 32'hA5A5_12EE);

    // CFG3 lands in the top slice
    axi_write(BASE + 32'h1C, 32'h1234_5678, 4'hF, 2'b00, 1, '0, 0);
    check("cfg3_slice", cfg_out[127:96], 32'h1234_5678);

    // Interrupt set, mask, W1C clear, and set-beats-clear
    axi_write(BASE + 32'h0C, 32'h8, 4'hF, 2'b00, 0, '0, 0);
    irq_event = 32'h8;
    @(posedge clk); #1;
    irq_event = '0;
    check("irq_after_event", 32'(irq), IRQ_EN ? 1 : 0);
    axi_write(BASE + 32'h08, 32'h8, 4'hF, 2'b00, 0, '0, 0);
    check("irq_after_w1c", 32'(irq), 0);
    axi_read(BASE + 32'h08, 2'b00, 32'h0, 0);
    axi_write(BASE + 32'h08, 32'h8, 4'hF, 2'b00, 0, 32'h8, 0);
    check("irq_set_beats_clear", 32'(irq), IRQ_EN ? 1 : 0);
    axi_read(BASE + 32'h08, 2'b00, IRQ_EN ? 32'h8 : 32'h0, 0);
    axi_read(BASE + 32'h0C, 2'b00, IRQ_EN ? 32'h8 : 32'h0, 0);

    // STATUS read with Rready held off
    status_in = 32'hDEAD_BEEF;
    axi_read(BASE + 32'h04, 2'b00, 32'hDEAD_BEEF, 4);

    // STATUS is read-only
    axi_write(BASE + 32'h04, 32'h1234_0000, 4'hF, 2'b10, 0, '0, 0);
    axi_read(BASE + 32'h04, 2'b00, 32'hDEAD_BEEF, 0);

    // Decode errors on both channels
    axi_read(BASE + 32'h40, 2'b11, 32'h0, 0);
    axi_write(BASE + 32'h20, 32'h0BAD_0BAD, 4'hF, 2'b11, 0, '0, 0);
    check("decerr_write_discarded", ctrl_out, 32'hA5A5_12EE);
    axi_read(BASE + 32'h00, 2'b00, 32'hA5A5_12EE, 0);

    // Reset while B is pending
    axi_write(BASE + 32'h00, 32'hFFFF_0000, 4'hF, 2'b00, 0, '0, 1);
    check("pending_bvalid", 32'(Bvalid), 1);
    check("ctrl_before_reset", ctrl_out, 32'hFFFF_0000);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_drops_bvalid", 32'(Bvalid), 0);
    check("reset_reloads_ctrl", ctrl_out, CR);
    check("reset_reloads_cfg3", cfg_out[127:96], 0);
    reset = 1'b0;
    #1;
    check("awready_after_reset", 32'(AWready), 1);

    check("scoreboard_empty", 32'(bq.size() + rq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
